// File: rtl/mem_arbiter.sv
// Fetch/data arbiter in front of a single 32-bit memory. It decodes the address map,
// rejects illegal accesses, extracts load lanes and turns sub-word stores into read-modify-write.
module mem_arbiter (
    input  logic        clk,
    input  logic        rst,
    input  logic        if_req,
    input  logic [31:0] if_addr,
    output logic        if_ack,
    output logic [31:0] if_rdata,
    output logic        if_fault,
    input  logic        d_req,
    input  logic        d_we,
    input  logic [1:0]  d_size,
    input  logic [31:0] d_addr,
    input  logic [31:0] d_wdata,
    output logic        d_ack,
    output logic [31:0] d_rdata,
    output logic        d_fault,
    output logic [31:0] mem_addr,
    output logic        mem_w_en,
    output logic [31:0] mem_wdata,
    input  logic [31:0] mem_rdata
);
    localparam logic [31:0] SRAM_BASE = 32'h0002_0000;
    localparam logic [31:0] MAP_END   = 32'h0003_FFFF;

    typedef enum logic [2:0] {S_IDLE, S_READ, S_WRITE, S_MERGE_WR, S_RESP} state_t;

    state_t      r_state;
    logic        r_last_d;     // 1 = data port was granted last
    logic        r_port_d;     // 1 = current access belongs to the data port
    logic        r_we;
    logic [1:0]  r_size;
    logic [1:0]  r_lane;
    logic [15:0] r_wdata;

    logic        w_any_req;
    logic        w_grant_d;
    logic [31:0] w_sel_addr;
    logic [1:0]  w_sel_size;
    logic        w_sel_we;
    logic        w_fault;
    logic [7:0]  w_rd_byte;
    logic [15:0] w_rd_half;
    logic [31:0] w_load_data;
    logic [31:0] w_merge;
    logic        w_resp_go;
    logic        w_resp_port;
    logic        w_resp_fault;
    logic [31:0] w_resp_data;

    // Round-robin: on a tie the port not granted last wins.
    assign w_any_req  = if_req | d_req;
    assign w_grant_d  = d_req & (~if_req | ~r_last_d);
    assign w_sel_addr = w_grant_d ? d_addr : if_addr;
    assign w_sel_size = w_grant_d ? d_size : 2'd2;
    assign w_sel_we   = w_grant_d & d_we;

    assign w_fault = (w_sel_size == 2'd3)
                   | ((w_sel_size == 2'd1) & w_sel_addr[0])
                   | ((w_sel_size == 2'd2) & (w_sel_addr[1:0] != 2'b00))
                   | (w_sel_addr > MAP_END)
                   | (w_sel_we & (w_sel_addr < SRAM_BASE));

    assign w_rd_byte = mem_rdata[{r_lane, 3'b000} +: 8];
    assign w_rd_half = r_lane[1] ? mem_rdata[31:16] : mem_rdata[15:0];

    always_comb begin
        case (r_size)
            2'd0:    w_load_data = {24'd0, w_rd_byte};
            2'd1:    w_load_data = {16'd0, w_rd_half};
            default: w_load_data = mem_rdata;
        endcase
    end

    // Per-lane merge of store data into the word read back during READ.
    generate
        for (genvar gi = 0; gi < 4; gi++) begin : g_lane
            localparam logic [1:0] LANE = gi[1:0];
            logic w_lane_en;
            assign w_lane_en = (r_size == 2'd0) ? (r_lane == LANE) : (r_lane[1] == LANE[1]);
            assign w_merge[gi*8 +: 8] = !w_lane_en ? mem_rdata[gi*8 +: 8]
                                      : (r_size == 2'd0) ? r_wdata[7:0]
                                      : r_wdata[LANE[0]*8 +: 8];
        end
    endgenerate

    // Response produced on the edge that enters RESP; ack is then high for the RESP cycle.
    always_comb begin
        w_resp_go    = 1'b0;
        w_resp_port  = r_port_d;
        w_resp_fault = 1'b0;
        w_resp_data  = 32'd0;
        case (r_state)
            S_IDLE: begin
                if (w_any_req && w_fault) begin
                    w_resp_go    = 1'b1;
                    w_resp_port  = w_grant_d;
                    w_resp_fault = 1'b1;
                end
            end
            S_READ: begin
                if (!r_we) begin
                    w_resp_go   = 1'b1;
                    w_resp_data = w_load_data;
                end
            end
            S_WRITE, S_MERGE_WR: w_resp_go = 1'b1;
            default: w_resp_go = 1'b0;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state   <= S_IDLE;
            r_last_d  <= 1'b0;
            r_port_d  <= 1'b0;
            r_we      <= 1'b0;
            r_size    <= 2'd0;
            r_lane    <= 2'd0;
            r_wdata   <= 16'd0;
            if_ack    <= 1'b0;
            if_rdata  <= 32'd0;
            if_fault  <= 1'b0;
            d_ack     <= 1'b0;
            d_rdata   <= 32'd0;
            d_fault   <= 1'b0;
            mem_addr  <= 32'd0;
            mem_w_en  <= 1'b0;
            mem_wdata <= 32'd0;
        end else begin
            if_ack   <= 1'b0;
            d_ack    <= 1'b0;
            mem_w_en <= 1'b0;

            if (w_resp_go) begin
                if (w_resp_port) begin
                    d_ack   <= 1'b1;
                    d_rdata <= w_resp_data;
                    d_fault <= w_resp_fault;
                end else begin
                    if_ack   <= 1'b1;
                    if_rdata <= w_resp_data;
                    if_fault <= w_resp_fault;
                end
            end

            case (r_state)
                S_IDLE: begin
                    if (w_any_req) begin
                        r_last_d <= w_grant_d;
                        r_port_d <= w_grant_d;
                        r_we     <= w_sel_we;
                        r_size   <= w_sel_size;
                        r_lane   <= w_sel_addr[1:0];
                        r_wdata  <= d_wdata[15:0];
                        if (w_fault) begin
                            r_state <= S_RESP;
                        end else if (w_sel_we && (w_sel_size == 2'd2)) begin
                            r_state   <= S_WRITE;
                            mem_addr  <= {w_sel_addr[31:2], 2'b00};
                            mem_w_en  <= 1'b1;
                            mem_wdata <= d_wdata;
                        end else begin
                            r_state  <= S_READ;
                            mem_addr <= {w_sel_addr[31:2], 2'b00};
                        end
                    end
                end
                S_READ: begin
                    if (r_we) begin
                        r_state   <= S_MERGE_WR;
                        mem_w_en  <= 1'b1;
                        mem_wdata <= w_merge;
                    end else begin
                        r_state <= S_RESP;
                    end
                end
                S_WRITE, S_MERGE_WR: r_state <= S_RESP;
                default: r_state <= S_IDLE;
            endcase
        end
    end
endmodule

// File: doc/mem_arbiter.md
# mem_arbiter

Two-port arbiter and access sequencer that places the core's instruction-fetch port and load/store port in front of the single byte-addressed, 32-bit-wide system memory. It decodes the ROM/SRAM/peripheral map and rejects illegal accesses. Sub-word loads are converted to aligned word reads with lane extraction. Sub-word stores are converted to read-modify-write sequences, so the memory only ever sees aligned 32-bit accesses.

## Interface
- ROM_BASE, 32'h0000_0000, first ROM byte; ROM is read-only.
- SRAM_BASE, 32'h0002_0000, first SRAM byte.
- PERIPH_BASE, 32'h0003_0000, first peripheral byte.
- MAP_END, 32'h0003_FFFF, last legal byte address.
- clk  in  1  system clock; all state changes on rising edge.
- rst  in  1  synchronous, active-high reset.
- if_req  in  1  fetch request; held until if_ack.
- if_addr  in  32  fetch byte address; word access only.
- if_ack  out  1  one-cycle completion pulse for fetch.
- if_rdata  out  32  fetched word; valid with if_ack, held until next if_ack.
- if_fault  out  1  fetch rejected; valid with if_ack.
- d_req  in  1  data request; held, with all d_* inputs stable, until d_ack.
- d_we  in  1  1 = store, 0 = load.
- d_size  in  2  0 = byte, 1 = halfword, 2 = word; 3 is illegal.
- d_addr  in  32  data byte address.
- d_wdata  in  32  store data, right-justified.
- d_ack  out  1  one-cycle completion pulse for data.
- d_rdata  out  32  load data, zero-extended, right-justified; held until next d_ack.
- d_fault  out  1  data access rejected; valid with d_ack.
- mem_addr  out  32  memory byte address; always word-aligned.
- mem_w_en  out  1  memory write enable, registered.
- mem_wdata  out  32  memory write word, registered.
- mem_rdata  in  32  memory read word; combinational from mem_addr.

## Operation
- FSM states: IDLE, READ, WRITE, MERGE_WR, RESP.
- IDLE: sample requests. Latch the port, address, size, we and wdata into internal registers; run checks; pick the next state.
- Arbitration:
  - Only one request pending: grant it.
  - Both pending: grant the port not granted last (round-robin).
  - `last` resets to fetch, so data wins the first tie.
- Fault checks, any one of which makes the access fault:
  - d_size = 3.
  - Halfword with addr[0] = 1.
  - Word (or any fetch) with addr[1:0] ≠ 0.
  - addr > MAP_END.
  - Store with ROM_BASE ≤ addr < SRAM_BASE.
- Faulting access: IDLE → RESP directly. No memory cycle. rdata = 0, fault = 1.
- Routing of legal accesses:
  - Load or fetch: IDLE → READ → RESP. In READ, mem_addr = addr & ~3; mem_rdata is captured at the end of READ. Lane extraction is byte: addr[1:0]·8; halfword: addr[1]·16.
  - Word store: IDLE → WRITE → RESP. In WRITE, mem_w_en = 1 and mem_wdata = wdata.
  - Byte/halfword store: IDLE → READ → MERGE_WR → RESP. MERGE_WR writes the captured word with only the addressed lane(s) replaced by wdata[7:0] or wdata[15:0].
- RESP: pulse ack on the granted port and update that port's rdata/fault registers. Return to IDLE.
- The other port's outputs never change during an access.
- The requester drops req on the edge where it samples ack. IDLE therefore never re-grants a completed request.
- mem_w_en is high only during WRITE and MERGE_WR, exactly one cycle per store. The memory commits on the falling edge inside that cycle.

## Timing
- Reset values (applied at the first rising edge with rst = 1):
  - state = IDLE; last = fetch.
  - if_ack = d_ack = 0; if_fault = d_fault = 0.
  - if_rdata = d_rdata = 0.
  - mem_w_en = 0; mem_addr = 0; mem_wdata = 0.
- ack latency, counted from the IDLE sampling edge: fault +1 cycle, load/fetch +2, word store +2, sub-word store +3.
- Throughput: one IDLE cycle between consecutive accesses. Back-to-back word loads complete every 3 cycles.
- Reset mid-operation: at the rst edge, the FSM goes to IDLE and no ack is issued for the aborted access. mem_w_en is 0 in the following cycle. A store whose WRITE/MERGE_WR cycle coincides with the rst edge may already have committed.
- A request arriving while not in IDLE waits. It is evaluated at the next IDLE cycle.

## Test plan
- Reset, preload word 0x11111111 @0x0000_0000 and 0x22222222 @0x0002_0000. Raise if_req (0x0) and d_req (load word 0x0002_0000) in the same cycle → d_ack at +2 with 0x22222222, then if_ack with 0x11111111 three cycles later.
- Word 0x11223344 @0x0002_0000; byte store 0xA5 to 0x0002_0001 → d_ack at +3, exactly one mem_w_en cycle with mem_addr 0x0002_0000, memory word becomes 0x1122A544.
- Word 0x98BADCFF @0x0002_0000; halfword load 0x0002_0002 → d_rdata 0x000098BA; byte load 0x0002_0001 → 0x000000DC.
- Word store to 0x0000_0100 (ROM), word load from 0x0002_0002, and d_size = 3 → each gives d_fault = 1 and d_rdata = 0 at +1; mem_w_en never asserts.
- Both ports hold requests continuously for 4 accesses → grant order data, fetch, data, fetch.
- Assert rst during the READ cycle of a byte store → IDLE next cycle, no d_ack, mem_w_en stays 0, target word unchanged.
